bin_to_bcd6: RTL and testbench
==============================

Name: bin_to_bcd6

Overview:
- Sequential shift-and-add-3 (double-dabble) converter. Turns a binary fuel quantity (e.g. volume pumped, in 0.01 L units) into six BCD digits.
- Sits directly upstream of the 7-segment decoder stage; its outputs bcd_HEX0..bcd_HEX5 feed that stage's digit inputs one-to-one.
- Outputs are registered and hold their value between conversions, so the display never flickers mid-conversion.

Parameters:
- IN_W, 20, width of the binary input; legal range 1..20.
- MAX_VAL, 999999, saturation limit; must be ≤ 999999 and < 2^IN_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion of in_value; sampled only when busy=0
- in_value  input  IN_W  unsigned binary value to convert
- busy  output  1  conversion in progress; start is ignored while high
- done  output  1  one-cycle pulse; bcd_HEXn and ovf are updated on the same edge
- ovf  output  1  last converted value exceeded MAX_VAL and was clamped
- bcd_HEX0  output  4  ones digit
- bcd_HEX1  output  4  tens digit
- bcd_HEX2  output  4  hundreds digit
- bcd_HEX3  output  4  thousands digit
- bcd_HEX4  output  4  ten-thousands digit
- bcd_HEX5  output  4  hundred-thousands digit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ovf=0, all bcd_HEXn=4'd0, FSM=IDLE, iteration counter=0.
- Reset asserted mid-conversion aborts the conversion. Outputs return to their reset values on the next edge; no done pulse is produced.
- FSM states are IDLE, SHIFT and LOAD_OUT.
- IDLE:
  - On an edge with start=1, latch the operand as min(in_value, MAX_VAL).
  - Latch ovf_pending = (in_value > MAX_VAL).
  - Clear the 24-bit BCD accumulator and the counter, then go to SHIFT. busy=1 from this edge.
- SHIFT, one iteration per clock:
  - For each of the six digits, if the digit is ≥ 5, add 3 (4-bit result, no carry between digits).
  - Then shift {accumulator, operand} left by 1.
  - Increment the counter. After IN_W iterations, go to LOAD_OUT.
- LOAD_OUT (single cycle):
  - Register the accumulator digits into bcd_HEX0..bcd_HEX5.
  - Set ovf=ovf_pending and done=1 for exactly one cycle.
  - busy=0 from this edge; return to IDLE.
- Latency: start is accepted at edge k, shifts occur at edges k+1..k+IN_W, and outputs plus done appear at edge k+IN_W+1 (21 cycles for the default).
  - Earliest next accepted start is edge k+IN_W+2; the maximum rate is one conversion per IN_W+2 cycles.
- start while busy=1 (including the LOAD_OUT cycle) is ignored, not queued.
- in_value is sampled only at the accepting edge; later changes have no effect on the conversion in progress.
- Digit outputs are always 0..9, except for the blank code under the optional feature. Values 10..14 are never produced.
- ovf and the digits hold until the next done pulse or reset.

Optional Feature:
- Macro name: BCD_LZ_BLANK_EN.
- Defined:
  - At LOAD_OUT, every leading zero digit from bcd_HEX5 down to bcd_HEX1 is replaced by 4'hF. The downstream decoder renders 4'hF as segments off.
  - bcd_HEX0 is never blanked.
  - Reset values become bcd_HEX5..bcd_HEX1=4'hF and bcd_HEX0=4'd0.
- Undefined: leading zeros are displayed and the reset values are as listed above.

Decomposition:
- Package fuel_disp_pkg holds:
  - N_DIGITS=6
  - BCD_W=4
  - BCD_BLANK=4'hF
  - MAX_DISP=999999
  - the FSM state encoding (IDLE/SHIFT/LOAD_OUT)
- One combinational sub-module, bcd_add3 (4-bit in, 4-bit out: +3 if ≥5), instantiated six times inside the SHIFT datapath.

Test Plan:
- Reset, then hold start=0 for 30 cycles -> busy=0, done=0, ovf=0, digits 0,0,0,0,0,0 (feature off) or F,F,F,F,F,0 (feature on).
- in_value=123456, start for 1 cycle -> done high exactly 21 cycles after the accepting edge; HEX5..HEX0=1,2,3,4,5,6; ovf=0; busy high for 21 cycles.
- in_value=999999 -> 9,9,9,9,9,9 with ovf=0; then in_value=1048575 -> 9,9,9,9,9,9 with ovf=1; then in_value=7 -> 0,0,0,0,0,7 with ovf cleared.
- Start 123456, pulse start with in_value=555 at cycle 5 and again in the LOAD_OUT cycle -> a single done pulse only, result 123456. Start accepted the following cycle -> 000555 after 21 more cycles.
- Assert rst at cycle 10 of a conversion of 654321 -> no done pulse; outputs equal the reset values on the next edge; a fresh start converts correctly.
- With BCD_LZ_BLANK_EN: in_value=42 -> F,F,F,F,4,2; in_value=0 -> F,F,F,F,F,0; in_value=100000 -> 1,0,0,0,0,0 (inner zeros not blanked).

Source files
------------

// File: rtl/fuel_disp_pkg.sv
// Shared constants, FSM encoding and display helpers for the fuel-display datapath.
package fuel_disp_pkg;

    localparam int          N_DIGITS  = 6;
    localparam int          BCD_W     = 4;
    localparam int          DISP_W    = N_DIGITS * BCD_W;
    localparam logic [3:0]  BCD_BLANK = 4'hF;
    localparam int          MAX_DISP  = 999999;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        LOAD_OUT = 2'd2
    } conv_state_e;

    // Replace leading zero digits (most significant down to the tens digit) with
    // the blank code; the ones digit always stays visible.
    function automatic logic [DISP_W-1:0] blank_leading_zeros(input logic [DISP_W-1:0] digits);
        logic [DISP_W-1:0] result;
        logic              leading;
        result  = digits;
        leading = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (leading && (digits[i*BCD_W +: BCD_W] == '0)) begin
                result[i*BCD_W +: BCD_W] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd6.sv
// Sequential binary-to-6-digit-BCD converter (shift-and-add-3), saturating at MAX_VAL.
// Optional build macro BCD_LZ_BLANK_EN blanks leading zero digits with the 4'hF code.
module bin_to_bcd6
    import fuel_disp_pkg::*;
#(
    parameter int IN_W    = 20,
    parameter int MAX_VAL = MAX_DISP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] in_value,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      bcd_HEX0,
    output logic [3:0]      bcd_HEX1,
    output logic [3:0]      bcd_HEX2,
    output logic [3:0]      bcd_HEX3,
    output logic [3:0]      bcd_HEX4,
    output logic [3:0]      bcd_HEX5
);

    localparam int               CNT_W    = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]  MAX_OP   = IN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
`ifdef BCD_LZ_BLANK_EN
    localparam logic [DISP_W-1:0] HEX_RST = {{(N_DIGITS-1){BCD_BLANK}}, 4'd0};
`else
    localparam logic [DISP_W-1:0] HEX_RST = '0;
`endif

    conv_state_e       state_q, state_d;
    logic [IN_W-1:0]   operand_q, operand_d;
    logic [DISP_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [DISP_W-1:0] hex_q, hex_d;

    logic [DISP_W-1:0] acc_adj;

    // One correction cell per decade, all working on the current accumulator.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_q[gi*BCD_W +: BCD_W]),
            .dout (acc_adj[gi*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        hex_d      = hex_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    operand_d  = (in_value > MAX_OP) ? MAX_OP : in_value;
                    ovf_pend_d = (in_value > MAX_OP);
                    acc_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The bit shifted out of the top digit is always zero for legal operands.
                {acc_d, operand_d} = {acc_adj, operand_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = LOAD_OUT;
                end
            end
            LOAD_OUT: begin
`ifdef BCD_LZ_BLANK_EN
                hex_d = blank_leading_zeros(acc_q);
`else
                hex_d = acc_q;
`endif
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            operand_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            hex_q      <= HEX_RST;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            hex_q      <= hex_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign bcd_HEX0 = hex_q[0*BCD_W +: BCD_W];
    assign bcd_HEX1 = hex_q[1*BCD_W +: BCD_W];
    assign bcd_HEX2 = hex_q[2*BCD_W +: BCD_W];
    assign bcd_HEX3 = hex_q[3*BCD_W +: BCD_W];
    assign bcd_HEX4 = hex_q[4*BCD_W +: BCD_W];
    assign bcd_HEX5 = hex_q[5*BCD_W +: BCD_W];

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Self-checking bench for bin_to_bcd6: directed scenarios plus randomized values
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] in_value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  bcd_HEX0, bcd_HEX1, bcd_HEX2, bcd_HEX3, bcd_HEX4, bcd_HEX5;

    int checks = 0;
    int errors = 0;

    bin_to_bcd6 #(.IN_W(20), .MAX_VAL(999999)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_value (in_value),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .bcd_HEX0 (bcd_HEX0),
        .bcd_HEX1 (bcd_HEX1),
        .bcd_HEX2 (bcd_HEX2),
        .bcd_HEX3 (bcd_HEX3),
        .bcd_HEX4 (bcd_HEX4),
        .bcd_HEX5 (bcd_HEX5)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] hex_all();
        return {bcd_HEX5, bcd_HEX4, bcd_HEX3, bcd_HEX2, bcd_HEX1, bcd_HEX0};
    endfunction

    // Expected display for a raw input: clamp, then split into decimal digits.
    function automatic logic [23:0] model_hex(input int unsigned v);
        int unsigned sat;
        int unsigned pw;
        logic [23:0] r;
        sat = (v > 999999) ? 999999 : v;
        pw  = 1;
        r   = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'((sat / pw) % 10);
`ifdef BCD_LZ_BLANK_EN
            if (i > 0 && sat < pw) r[i*4 +: 4] = 4'hF;
`endif
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] reset_hex();
`ifdef BCD_LZ_BLANK_EN
        return 24'hFFFFF0;
`else
        return 24'h000000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion and follow it to its done pulse, checking timing and result.
    task automatic convert(input int unsigned v);
        int cyc;
        int busy_cnt;
        in_value = 20'(v);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_value = 20'($urandom);
        busy_cnt = busy ? 1 : 0;
        cyc      = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
        end
        check("latency", 32'(cyc), 32'd21);
        check("busy_cycles", 32'(busy_cnt), 32'd21);
        check("digits", {8'h0, hex_all()}, {8'h0, model_hex(v)});
        check("ovf", {31'h0, ovf}, {31'h0, (v > 999999)});
        $display("conv in=%0d hex=%06h ovf=%0b latency=%0d", v, hex_all(), ovf, cyc);
        tick();
        check("done_width", {31'h0, done}, 32'h0);
    endtask

    initial begin
        int dones;
        int cyc;
        rst      = 1'b1;
        start    = 1'b0;
        in_value = '0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        dones = 0;
        repeat (30) begin
            tick();
            if (done) dones++;
        end
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_done_count", 32'(dones), 32'h0);
        check("idle_ovf", {31'h0, ovf}, 32'h0);
        check("idle_digits", {8'h0, hex_all()}, {8'h0, reset_hex()});
        $display("reset idle hex=%06h busy=%0b ovf=%0b", hex_all(), busy, ovf);

        // Directed values, including saturation and ovf clearing
        convert(123456);
        convert(999999);
        convert(1048575);
        convert(7);

        // Starts during a conversion and in its LOAD_OUT cycle are ignored
        in_value = 20'd123456;
        start    = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) begin
                start    = 1'b1;
                in_value = 20'd555;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) dones++;
        end
        start    = 1'b1;
        in_value = 20'd555;
        tick();
        check("ignore_early_done", 32'(dones), 32'h0);
        check("ignore_done", {31'h0, done}, 32'h1);
        check("ignore_digits", {8'h0, hex_all()}, {8'h0, model_hex(123456)});
        $display("ignored starts: hex=%06h done=%0b", hex_all(), done);
        tick();
        start = 1'b0;
        check("next_accept_busy", {31'h0, busy}, 32'h1);
        check("next_accept_done", {31'h0, done}, 32'h0);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("next_latency", 32'(cyc), 32'd21);
        check("next_digits", {8'h0, hex_all()}, {8'h0, model_hex(555)});
        $display("follow-on conv in=555 hex=%06h latency=%0d", hex_all(), cyc);
        tick();

        // Reset aborts a conversion in flight
        convert(1048575);
        in_value = 20'd654321;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_ovf", {31'h0, ovf}, 32'h0);
        check("abort_digits", {8'h0, hex_all()}, {8'h0, reset_hex()});
        $display("abort: hex=%06h busy=%0b ovf=%0b", hex_all(), busy, ovf);
        rst   = 1'b0;
        dones = 0;
        repeat (25) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'h0);
        convert(654321);

`ifdef BCD_LZ_BLANK_EN
        convert(42);
        convert(0);
        convert(100000);
`endif

        // Randomized values across the full input range
        for (int n = 0; n < 20; n++) begin
            if (n % 2 == 0) convert($urandom_range(0, 999999));
            else            convert($urandom_range(0, 20'hFFFFF));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
